// File: rtl/clk_x4_slot_scheduler_pkg.sv
// Shared types for the x4 slot scheduler and its phase tracker.
// Channel index, phase enum and the in-flight tag carried through the resource latency.
package clk_x4_slot_scheduler_pkg;

    localparam int unsigned NUM_CHANNELS = 4;

    typedef logic [1:0] channel_t;

    typedef enum logic [1:0] {
        PHASE_0,
        PHASE_1,
        PHASE_2,
        PHASE_3
    } phase_t;

    typedef struct packed {
        logic     valid;
        channel_t channel;
    } tag_t;

    function automatic logic is_one_hot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/clk_x4_phase_tracker.sv
// Tracks the rotating x4 phase markers: reports the current phase, whether the cycle is in sync,
// and a sticky error for malformed or out-of-order marker vectors.
module clk_x4_phase_tracker
    import clk_x4_slot_scheduler_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] markers_i,
    output phase_t     phase_o,
    output logic       sync_o,
    output logic       err_phase_o
);

    logic   synced_q, synced_d;
    phase_t expected_q, expected_d;
    logic   err_q, err_d;
    logic   one_hot;
    phase_t cur_phase;

    always_comb begin
        one_hot   = is_one_hot4(markers_i);
        cur_phase = PHASE_0;
        if (markers_i[1]) begin
            cur_phase = PHASE_1;
        end else if (markers_i[2]) begin
            cur_phase = PHASE_2;
        end else if (markers_i[3]) begin
            cur_phase = PHASE_3;
        end

        // Unsynced: only a clean p0 is accepted; synced: only the expected successor.
        sync_o = one_hot && (synced_q ? (cur_phase == expected_q) : (cur_phase == PHASE_0));

        synced_d   = sync_o;
        expected_d = phase_t'(cur_phase + 2'd1);
        err_d      = err_q | ~one_hot | (synced_q & (cur_phase != expected_q));
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            synced_q   <= 1'b0;
            expected_q <= PHASE_0;
            err_q      <= 1'b0;
        end else begin
            synced_q   <= synced_d;
            expected_q <= expected_d;
            err_q      <= err_d;
        end
    end

    assign phase_o     = cur_phase;
    assign err_phase_o = err_q;

endmodule

// File: rtl/clk_x4_slot_scheduler.sv
// Shares one pipelined resource between four channels using x4 phase slots (phase n owns channel n).
// Define CLK_X4_SLOT_SCHEDULER_BORROW_EN to let idle owner slots go round-robin to other channels.
module clk_x4_slot_scheduler
    import clk_x4_slot_scheduler_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned RESULT_WIDTH = 32,
    parameter int unsigned LATENCY      = 3
) (
    input  logic                                       Clk,
    input  logic                                       Rst,
    input  logic                                       Clk_x4_p0,
    input  logic                                       Clk_x4_p1,
    input  logic                                       Clk_x4_p2,
    input  logic                                       Clk_x4_p3,
    input  logic [NUM_CHANNELS-1:0]                    Req_valid,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]    Req_data,
    output logic [NUM_CHANNELS-1:0]                    Req_ready,
    output logic                                       Res_valid,
    output logic [DATA_WIDTH-1:0]                      Res_data,
    output logic [1:0]                                 Res_channel,
    input  logic [RESULT_WIDTH-1:0]                    Res_result_data,
    output logic [NUM_CHANNELS-1:0]                    Out_valid,
    output logic [NUM_CHANNELS-1:0][RESULT_WIDTH-1:0]  Out_data,
    output logic                                       Err_phase
);

    phase_t phase;
    logic   sync;

    clk_x4_phase_tracker u_phase_tracker (
        .Clk        (Clk),
        .Rst        (Rst),
        .markers_i  ({Clk_x4_p3, Clk_x4_p2, Clk_x4_p1, Clk_x4_p0}),
        .phase_o    (phase),
        .sync_o     (sync),
        .err_phase_o(Err_phase)
    );

    logic [NUM_CHANNELS-1:0] granted_q, granted_d, granted_eff, eligible;
    logic                    grant_vld;
    channel_t                grant_ch;

    logic                                      res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0]                     res_data_q, res_data_d;
    channel_t                                  res_channel_q, res_channel_d;
    tag_t                                      tag_q [LATENCY];
    tag_t                                      tag_d [LATENCY];
    logic [NUM_CHANNELS-1:0]                   out_valid_q, out_valid_d;
    logic [NUM_CHANNELS-1:0][RESULT_WIDTH-1:0] out_data_q, out_data_d;

`ifdef CLK_X4_SLOT_SCHEDULER_BORROW_EN
    channel_t rr_ptr_q, rr_ptr_d;
    channel_t cand;
`endif

    always_comb begin
        // The p0 clear takes effect for eligibility in the same cycle.
        granted_eff = Clk_x4_p0 ? '0 : granted_q;
        eligible    = Req_valid & ~granted_eff;
        grant_vld   = 1'b0;
        grant_ch    = channel_t'(phase);
`ifdef CLK_X4_SLOT_SCHEDULER_BORROW_EN
        rr_ptr_d = rr_ptr_q;
        cand     = rr_ptr_q;
`endif
        if (!Rst && sync) begin
            if (eligible[phase]) begin
                grant_vld = 1'b1;
            end
`ifdef CLK_X4_SLOT_SCHEDULER_BORROW_EN
            else begin
                for (int k = 0; k < NUM_CHANNELS; k++) begin
                    cand = rr_ptr_q + channel_t'(k);
                    if (!grant_vld && eligible[cand]) begin
                        grant_vld = 1'b1;
                        grant_ch  = cand;
                    end
                end
                if (grant_vld) begin
                    rr_ptr_d = grant_ch + 2'd1;
                end
            end
`endif
        end
        Req_ready = grant_vld ? (4'b0001 << grant_ch) : 4'b0000;
        granted_d = granted_eff | Req_ready;
    end

    always_comb begin
        res_valid_d   = grant_vld;
        res_data_d    = grant_vld ? Req_data[grant_ch] : res_data_q;
        res_channel_d = grant_vld ? grant_ch : res_channel_q;

        tag_d[0].valid   = res_valid_q;
        tag_d[0].channel = res_channel_q;
        for (int i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        // The last tap lines up with the resource output for the op it describes.
        out_valid_d = '0;
        out_data_d  = out_data_q;
        if (tag_q[LATENCY-1].valid) begin
            out_valid_d[tag_q[LATENCY-1].channel] = 1'b1;
            out_data_d[tag_q[LATENCY-1].channel]  = Res_result_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            granted_q     <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_channel_q <= '0;
            out_valid_q   <= '0;
            out_data_q    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            granted_q     <= granted_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_channel_q <= res_channel_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            tag_q         <= tag_d;
        end
    end

`ifdef CLK_X4_SLOT_SCHEDULER_BORROW_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign Res_valid   = res_valid_q;
    assign Res_data    = res_data_q;
    assign Res_channel = res_channel_q;
    assign Out_valid   = out_valid_q;
    assign Out_data    = out_data_q;

endmodule

// File: tb/tb_clk_x4_slot_scheduler.sv
// Drives two schedulers (LATENCY 3 and 1) with the same randomized traffic and compares every cycle
// against a slot/window model that schedules expected issues and results by cycle number.
module tb_clk_x4_slot_scheduler;

    localparam int DW   = 16;
    localparam int RW   = 32;
    localparam int RING = 16;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic                  Rst = 1'b1;
    logic [3:0]            mk = 4'b0001;
    logic [3:0]            req_valid = '0;
    logic [3:0][DW-1:0]    req_data = '0;

    logic [3:0]            req_ready [2];
    logic                  res_valid [2];
    logic [DW-1:0]         res_data [2];
    logic [1:0]            res_channel [2];
    logic [RW-1:0]         res_result [2];
    logic [3:0]            out_valid [2];
    logic [3:0][RW-1:0]    out_data [2];
    logic                  err_phase [2];

    // Resource: doubles the issued operand, LATENCY cycles later.
    logic [RW-1:0] hist3 [3];
    logic [RW-1:0] hist1;
    always @(posedge Clk) begin
        hist3[0] <= RW'({res_data[0], 1'b0});
        hist3[1] <= hist3[0];
        hist3[2] <= hist3[1];
        hist1    <= RW'({res_data[1], 1'b0});
    end
    assign res_result[0] = hist3[2];
    assign res_result[1] = hist1;

    clk_x4_slot_scheduler #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .LATENCY(3)) u_dut3 (
        .Clk(Clk), .Rst(Rst),
        .Clk_x4_p0(mk[0]), .Clk_x4_p1(mk[1]), .Clk_x4_p2(mk[2]), .Clk_x4_p3(mk[3]),
        .Req_valid(req_valid), .Req_data(req_data), .Req_ready(req_ready[0]),
        .Res_valid(res_valid[0]), .Res_data(res_data[0]), .Res_channel(res_channel[0]),
        .Res_result_data(res_result[0]), .Out_valid(out_valid[0]), .Out_data(out_data[0]),
        .Err_phase(err_phase[0])
    );

    clk_x4_slot_scheduler #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .LATENCY(1)) u_dut1 (
        .Clk(Clk), .Rst(Rst),
        .Clk_x4_p0(mk[0]), .Clk_x4_p1(mk[1]), .Clk_x4_p2(mk[2]), .Clk_x4_p3(mk[3]),
        .Req_valid(req_valid), .Req_data(req_data), .Req_ready(req_ready[1]),
        .Res_valid(res_valid[1]), .Res_data(res_data[1]), .Res_channel(res_channel[1]),
        .Res_result_data(res_result[1]), .Out_valid(out_valid[1]), .Out_data(out_data[1]),
        .Err_phase(err_phase[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got=%0h want=%0h", tag, $time, act, exp);
        end
    endtask

    // Model state
    int     cyc = 0;
    bit     m_sync, m_err, m_res_zero;
    int     m_next, m_ptr;
    bit [3:0] m_gr;
    bit     e_res_v [RING];
    int     e_res_ch [RING];
    int     e_res_d [RING];
    int     e_out_ch [2][RING];
    longint e_out_val [2][RING];
    longint m_out [2][4];
    int     lat [2] = '{3, 1};

    // Stimulus state
    int ph_cnt = 2;
    bit pend [4];
    int prob [4];
    bit hold_phase, bad_vec;
    int rst_cycles;
    bit borrow_track;
    int borrow_ph;

    task automatic model_reset();
        m_sync = 0; m_err = 0; m_gr = '0; m_ptr = 0; m_next = 0; m_res_zero = 1;
        for (int s = 0; s < RING; s++) begin
            e_res_v[s] = 0;
            for (int i = 0; i < 2; i++) e_out_ch[i][s] = -1;
        end
        for (int i = 0; i < 2; i++) for (int c = 0; c < 4; c++) m_out[i][c] = 0;
    endtask

    task automatic drive();
        Rst = (rst_cycles > 0);
        if (rst_cycles > 0) rst_cycles--;
        if (bad_vec) begin
            mk = 4'b0110;
            bad_vec = 0;
        end else begin
            mk = 4'(1 << ph_cnt);
        end
        if (hold_phase) hold_phase = 0;
        else ph_cnt = (ph_cnt + 1) % 4;
        for (int c = 0; c < 4; c++) begin
            if (!pend[c] && $urandom_range(99) < prob[c]) begin
                pend[c] = 1;
                req_data[c] = DW'($urandom);
            end
            req_valid[c] = pend[c];
        end
    endtask

    task automatic step();
        int s, ones, ph, grant;
        bit ok, bad;
        logic [3:0] exp_rdy;
        s = cyc % RING;
        for (int i = 0; i < 2; i++) begin
            logic [3:0]   ov;
            logic [127:0] od;
            string        pfx;
            pfx = $sformatf("L%0d ", lat[i]);
            ov = '0;
            if (e_out_ch[i][s] >= 0) begin
                ov[e_out_ch[i][s]] = 1'b1;
                m_out[i][e_out_ch[i][s]] = e_out_val[i][s];
            end
            od = {m_out[i][3][31:0], m_out[i][2][31:0], m_out[i][1][31:0], m_out[i][0][31:0]};
            check_eq({pfx, "res_valid"}, 128'(res_valid[i]), 128'(e_res_v[s]));
            if (e_res_v[s]) begin
                check_eq({pfx, "res_data"}, 128'(res_data[i]), 128'(e_res_d[s]));
                check_eq({pfx, "res_channel"}, 128'(res_channel[i]), 128'(e_res_ch[s]));
            end else if (m_res_zero) begin
                check_eq({pfx, "res_data_rst"}, 128'(res_data[i]), 128'(0));
                check_eq({pfx, "res_channel_rst"}, 128'(res_channel[i]), 128'(0));
            end
            check_eq({pfx, "out_valid"}, 128'(out_valid[i]), 128'(ov));
            check_eq({pfx, "out_data"}, out_data[i], od);
            check_eq({pfx, "err_phase"}, 128'(err_phase[i]), 128'(m_err));
            e_out_ch[i][s] = -1;
        end
        if (e_res_v[s]) m_res_zero = 0;
        e_res_v[s] = 0;

        grant = -1;
        if (Rst) begin
            check_eq("L3 req_ready_rst", 128'(req_ready[0]), 128'(0));
            check_eq("L1 req_ready_rst", 128'(req_ready[1]), 128'(0));
            model_reset();
        end else begin
            ones = $countones(mk);
            ph = 0;
            for (int k = 3; k >= 0; k--) if (mk[k]) ph = k;
            ok  = (ones == 1) && (m_sync ? (ph == m_next) : (ph == 0));
            bad = (ones != 1) || (m_sync && (ph != m_next));
            if (mk[0]) m_gr = '0;
            if (ok) begin
                if (req_valid[ph] && !m_gr[ph]) grant = ph;
`ifdef CLK_X4_SLOT_SCHEDULER_BORROW_EN
                else begin
                    for (int k = 0; k < 4; k++) begin
                        int c;
                        c = (m_ptr + k) % 4;
                        if (grant < 0 && req_valid[c] && !m_gr[c]) begin
                            grant = c;
                            m_ptr = (c + 1) % 4;
                        end
                    end
                end
`endif
            end
            exp_rdy = (grant >= 0) ? 4'(1 << grant) : 4'b0000;
            check_eq("L3 req_ready", 128'(req_ready[0]), 128'(exp_rdy));
            check_eq("L1 req_ready", 128'(req_ready[1]), 128'(exp_rdy));
            if (borrow_track && borrow_ph < 0 && req_ready[0][1]) borrow_ph = ph;
            if (bad) m_err = 1;
            m_sync = ok;
            m_next = (ph + 1) % 4;
            if (grant >= 0) begin
                m_gr[grant] = 1;
                e_res_v[(cyc + 1) % RING]  = 1;
                e_res_ch[(cyc + 1) % RING] = grant;
                e_res_d[(cyc + 1) % RING]  = int'(req_data[grant]);
                for (int i = 0; i < 2; i++) begin
                    e_out_ch[i][(cyc + lat[i] + 2) % RING]  = grant;
                    e_out_val[i][(cyc + lat[i] + 2) % RING] = 2 * longint'(req_data[grant]);
                end
                pend[grant] = 0;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
            drive();
            @(negedge Clk);
            step();
        end
    endtask

    task automatic set_prob(input int p0, input int p1, input int p2, input int p3);
        prob[0] = p0; prob[1] = p1; prob[2] = p2; prob[3] = p3;
    endtask

    initial begin
        int exp_borrow_ph;
        model_reset();
        for (int c = 0; c < 4; c++) pend[c] = 0;
        set_prob(0, 0, 0, 0);
        rst_cycles = 3;
        run(3);

        // Full load: strict owner rotation, back-to-back results.
        set_prob(100, 100, 100, 100);
        run(40);

        // Borrow: channel 1 raises valid in a p2 cycle with everyone else idle.
        set_prob(0, 0, 0, 0);
        run(12);
        for (int k = 0; k < 8; k++) begin
            if (ph_cnt == 2) break;
            run(1);
        end
        pend[1] = 1;
        req_data[1] = DW'($urandom);
        borrow_ph = -1;
        borrow_track = 1;
        run(8);
        borrow_track = 0;
`ifdef CLK_X4_SLOT_SCHEDULER_BORROW_EN
        exp_borrow_ph = 2;
`else
        exp_borrow_ph = 1;
`endif
        check_eq("borrow_phase", 128'(borrow_ph), 128'(exp_borrow_ph));

        // Once per window: only channel 0 asks, continuously.
        set_prob(100, 0, 0, 0);
        run(20);

        set_prob(50, 50, 50, 50);
        run(100);

        // Phase error: p1 repeated, then a non-one-hot vector.
        set_prob(100, 100, 100, 100);
        for (int k = 0; k < 8; k++) begin
            if (ph_cnt == 1) break;
            run(1);
        end
        hold_phase = 1;
        run(14);
        bad_vec = 1;
        run(12);

        // Reset mid-flight with ops in the pipe.
        run(5);
        rst_cycles = 1;
        run(24);

        for (int r = 0; r < 4; r++) begin
            set_prob($urandom_range(90, 20), $urandom_range(90, 20),
                     $urandom_range(90, 20), $urandom_range(90, 20));
            run(60);
            if ($urandom_range(1)) hold_phase = 1;
            run(20);
            rst_cycles = 1;
            run(10);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_x4_slot_scheduler.md
# clk_x4_slot_scheduler

Time-slot scheduler that shares one pipelined resource (e.g. a DSP multiply) between four requesters in the `Clk_x4` domain. It uses the four phase markers from the x4 phase marker as slot boundaries: phase n is owned by channel n. It issues at most one operation per cycle, tracks each operation's channel through the fixed resource latency, and steers each result back to its channel.

## Interface
- `DATA_WIDTH`, 16, request operand width
- `RESULT_WIDTH`, 32, resource result width
- `LATENCY`, 3, resource cycles from `Res_valid` to its result on `Res_result_data`; legal range is 1 or more.
- `Clk`  in  1  the x4 clock; every port is synchronous to it.
- `Rst`  in  1  reset; synchronous, active-high.
- `Clk_x4_p0`..`Clk_x4_p3`  in  1 each  phase markers; exactly one is high per cycle, rotating p0→p1→p2→p3.
- `Req_valid`  in  4  per-channel request valid.
- `Req_data`  in  4×DATA_WIDTH  per-channel operand.
- `Req_ready`  out  4  per-channel accept; combinational from `Req_valid`, phase and state.
- `Res_valid`  out  1  issue strobe to the shared resource.
- `Res_data`  out  DATA_WIDTH  issued operand.
- `Res_channel`  out  2  issued channel index; debug only.
- `Res_result_data`  in  RESULT_WIDTH  resource output, valid exactly `LATENCY` cycles after `Res_valid`.
- `Out_valid`  out  4  per-channel one-cycle result pulse.
- `Out_data`  out  4×RESULT_WIDTH  per-channel result, held until that channel's next result.
- `Err_phase`  out  1  sticky phase-marker error.

## Operation
- **Window:** the 4 cycles starting at a p0 cycle.
- **Granted-this-window bits (4):**
  - Cleared on every p0 cycle; the clear applies to eligibility in that same cycle.
  - Set when the channel is accepted.
  - A channel is accepted at most once per window.
- **Owner rule:** in phase n, channel n is accepted if `Req_valid[n]` is high and it has not been granted this window.
- **Handshake:**
  - Acceptance happens when `Req_valid` and `Req_ready` are both high.
  - At most one `Req_ready` bit is high per cycle.
  - A requester must not make `Req_valid` depend on `Req_ready`.
  - `Req_data` must be stable while valid is high.
- **Phase tracker:**
  - Holds the expected next phase.
  - After reset, the block is unsynced; the first one-hot p0 syncs it.
  - A marker vector that is not one-hot, or is not the expected successor:
    - sets `Err_phase` (sticky until `Rst`);
    - drops sync; no issue happens that cycle or until the next valid p0.
- **Tag pipeline:** a `LATENCY`-deep shift register of {valid, channel}, loaded when `Res_valid` is high. At the output tap:
  - `Res_result_data` is registered into `Out_data[ch]`;
  - `Out_valid[ch]` pulses for one cycle.
- The resource has no backpressure, so results are never dropped.

## Timing
- **Reset values:** `Req_ready`=0, `Res_valid`=0, `Res_data`=0, `Res_channel`=0, `Out_valid`=0, `Out_data`=0, `Err_phase`=0. The tag pipeline, granted bits and round-robin pointer are cleared.
- **Issue:** `Res_valid`, `Res_data` and `Res_channel` are registered, one cycle after acceptance.
- **Result:** `Out_valid` and `Out_data` appear `LATENCY`+1 cycles after `Res_valid`, i.e. `LATENCY`+2 cycles after acceptance.
- **Full load:** with all four channels valid continuously, grants in phases 0,1,2,3 go to channels 0,1,2,3. Sustained throughput is 1 op per cycle, 1 per channel per window.
- **Reset mid-operation:**
  - In-flight tags are discarded; no `Out_valid` pulse follows for operations issued before `Rst`.
  - `Out_data` returns to 0.
  - Issue resumes at the first valid p0 after `Rst` deasserts.
- **Simultaneous events:** an owner-slot acceptance and a result return in the same cycle are independent. The result of a previous op for channel n and a new acceptance of channel n may coincide.

## Configuration
- `CLK_X4_SLOT_SCHEDULER_BORROW_EN`
  - **Defined:** when the phase owner is not eligible (not valid or already granted), the idle slot goes to another eligible channel.
    - Round-robin search starts at a 2-bit pointer (reset 0).
    - On a borrow grant to channel c, the pointer becomes c+1 mod 4.
    - Owner grants do not move the pointer.
  - **Undefined:** strict TDM; an idle owner slot stays unused and the pointer logic is absent.

## Structure
- **Package `clk_x4_slot_scheduler_pkg`:**
  - `NUM_CHANNELS`=4;
  - `channel_t` (2-bit);
  - `phase_t` enum PHASE_0..PHASE_3;
  - the `tag_t` struct {valid, channel}.
- **Sub-module `clk_x4_phase_tracker`:** markers in; phase, sync and `Err_phase` out. It is reusable by other x4 consumers.

## Test plan
- **Full load:** all `Req_valid`=1, `LATENCY`=3, resource = identity×2 -> `Res_channel` sequence 0,1,2,3 repeating; each `Out_valid[n]` pulses once per window, 5 cycles after acceptance, with `Out_data`=2×operand.
- **Borrow:** channel 1 valid only from the p2 cycle, channel 2 idle.
  - With the macro: channel 1 is granted at p2.
  - Without the macro: channel 1 is granted at the next p1 and phase 2 stays empty.
- **Once per window:** channel 0 held valid with others idle, macro defined -> exactly one grant per window, at p0; no repeat grants in p1–p3.
- **Phase error:** p1 repeated twice -> `Err_phase`=1 from the next cycle and stays 1; no `Res_valid` until the next p0; issue then resumes.
- **Reset mid-flight:** `Rst` pulsed 1 cycle after three issues -> no `Out_valid` pulses for those ops; all outputs are 0; the first new grant occurs at the first p0 after release.
- **Parameter corners:** `LATENCY`=1 -> acceptance to `Out_valid` is 3 cycles, with back-to-back results for channels 0..3 on consecutive cycles.
